// File: rtl/bsg_level_shift_pkg.sv
// Shared types and limits for the level-shift isolation/capture slice.
package bsg_level_shift_pkg;

  typedef enum logic [1:0] {
    ISO    = 2'd0,
    WAKE   = 2'd1,
    ACTIVE = 2'd2,
    DRAIN  = 2'd3
  } bsg_ls_iso_state_e;

  localparam int unsigned bsg_ls_settle_max_lp = 255;

endpackage

// File: rtl/bsg_level_shift_iso_fsm.sv
// Isolation sequencer: owns the sink enable, the power-up settle count and
// the drain handshake back to ISO.
module bsg_level_shift_iso_fsm
  import bsg_level_shift_pkg::*;
#(
  parameter int unsigned settle_cycles_p = 4
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic pg_i,
  input  logic iso_req_i,
  input  logic buf_v_i,
  output logic en_o,
  output logic iso_ack_o,
  output logic cap_en_o
);

  localparam int unsigned settle_lp =
    (settle_cycles_p > bsg_ls_settle_max_lp) ? bsg_ls_settle_max_lp :
    (settle_cycles_p < 1) ? 1 : settle_cycles_p;
  localparam int unsigned cnt_w_lp = $clog2(settle_lp + 1);

  bsg_ls_iso_state_e   r_state, w_state_n;
  logic [cnt_w_lp-1:0] r_cnt, w_cnt_n;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= ISO;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
    end
  end

  // Power loss always wins over any pending isolate request.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    unique case (r_state)
      ISO: begin
        if (pg_i && !iso_req_i) begin
          w_state_n = WAKE;
          w_cnt_n   = cnt_w_lp'(settle_lp - 1);
        end
      end
      WAKE: begin
        if (!pg_i)                 w_state_n = ISO;
        else if (r_cnt == '0)      w_state_n = ACTIVE;
        else                       w_cnt_n   = r_cnt - cnt_w_lp'(1);
      end
      ACTIVE: begin
        if (!pg_i)                 w_state_n = ISO;
        else if (iso_req_i)        w_state_n = DRAIN;
      end
      DRAIN: begin
        if (!pg_i || !buf_v_i)     w_state_n = ISO;
      end
      default:                     w_state_n = ISO;
    endcase
  end

  assign en_o      = (r_state == WAKE) || (r_state == ACTIVE);
  assign iso_ack_o = (r_state == ISO);
  assign cap_en_o  = (r_state == ACTIVE);

endmodule

// File: rtl/bsg_level_shift_iso_capture.sv
// v1-domain capture stage behind the level-shift sink: isolation control plus
// a single-entry valid/ready output buffer. Option: BSG_LEVEL_SHIFT_ISO_SYNC_EN.
module bsg_level_shift_iso_capture
  import bsg_level_shift_pkg::*;
#(
  parameter int unsigned width_p         = 16,
  parameter int unsigned settle_cycles_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v0_pwr_good_i,
  input  logic               iso_req_i,
  output logic               en_o,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               ready_i,
  output logic               iso_ack_o,
  output logic               overflow_o
);

  logic w_pg_s;
  logic w_cap_en;
  logic w_cap_try;
  logic w_capture;
  logic w_drop;

`ifdef BSG_LEVEL_SHIFT_ISO_SYNC_EN
  logic [1:0] r_pg_sync;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_pg_sync <= 2'b00;
    else            r_pg_sync <= {r_pg_sync[0], v0_pwr_good_i};
  end

  assign w_pg_s = r_pg_sync[1];
`else
  assign w_pg_s = v0_pwr_good_i;
`endif

  bsg_level_shift_iso_fsm #(
    .settle_cycles_p(settle_cycles_p)
  ) u_fsm (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .pg_i      (w_pg_s),
    .iso_req_i (iso_req_i),
    .buf_v_i   (v_o),
    .en_o      (en_o),
    .iso_ack_o (iso_ack_o),
    .cap_en_o  (w_cap_en)
  );

  // Accept whenever the slot is empty or being drained this cycle.
  assign w_cap_try = w_cap_en & v_i;
  assign w_capture = w_cap_try & (~v_o | ready_i);
  assign w_drop    = w_cap_try & v_o & ~ready_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v_o        <= 1'b0;
      data_o     <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (w_capture)         v_o <= 1'b1;
      else if (v_o & ready_i) v_o <= 1'b0;
      if (w_capture)         data_o <= data_i;
      if (w_drop)            overflow_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bsg_level_shift_iso_capture.sv
// Directed bench for bsg_level_shift_iso_capture (width 16, settle 4);
// honours BSG_LEVEL_SHIFT_ISO_SYNC_EN for power-good timing.
module tb_bsg_level_shift_iso_capture;

`ifdef BSG_LEVEL_SHIFT_ISO_SYNC_EN
  localparam int unsigned sync_lp = 2;
`else
  localparam int unsigned sync_lp = 0;
`endif

  logic        clk;
  logic        reset_n;
  logic        pg;
  logic        iso_req;
  logic        en;
  logic        v_in;
  logic [15:0] data_in;
  logic        v_out;
  logic [15:0] data_out;
  logic        ready;
  logic        iso_ack;
  logic        overflow;

  int unsigned n_vec;
  int unsigned n_bad;

  bsg_level_shift_iso_capture #(
    .width_p(16),
    .settle_cycles_p(4)
  ) dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n),
    .v0_pwr_good_i (pg),
    .iso_req_i     (iso_req),
    .en_o          (en),
    .v_i           (v_in),
    .data_i        (data_in),
    .v_o           (v_out),
    .data_o        (data_out),
    .ready_i       (ready),
    .iso_ack_o     (iso_ack),
    .overflow_o    (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int unsigned n);
    for (int i = 0; i < int'(n); i++) step();
  endtask

  initial begin
    n_vec   = 0;
    n_bad   = 0;
    reset_n = 1'b0;
    pg      = 1'b0;
    iso_req = 1'b0;
    v_in    = 1'b0;
    data_in = 16'h0000;
    ready   = 1'b0;

    #2;
    check_eq("rst_en",   32'(en),       32'd0);
    check_eq("rst_v",    32'(v_out),    32'd0);
    check_eq("rst_data", 32'(data_out), 32'd0);
    check_eq("rst_ack",  32'(iso_ack),  32'd1);
    check_eq("rst_ovf",  32'(overflow), 32'd0);
    step();
    reset_n = 1'b1;
    step();
    check_eq("idle_ack", 32'(iso_ack), 32'd1);

    // Wake: pg sampled at edge 0, captures blocked through edge 4.
    pg = 1'b1;
    step_n(sync_lp);
    step();
    check_eq("wake_en",  32'(en),      32'd1);
    check_eq("wake_ack", 32'(iso_ack), 32'd0);
    v_in    = 1'b1;
    data_in = 16'hBEEF;
    for (int i = 1; i <= 4; i++) begin
      step();
      check_eq($sformatf("wake_block%0d", i), 32'(v_out), 32'd0);
    end
    data_in = 16'hA5A5;
    step();
    check_eq("wake_cap_v", 32'(v_out),    32'd1);
    check_eq("wake_cap_d", 32'(data_out), 32'h0000A5A5);

    // Streaming at full throughput.
    ready = 1'b1;
    for (int w = 0; w < 8; w++) begin
      data_in = 16'(w);
      step();
      check_eq($sformatf("stream_d%0d", w), 32'(data_out), 32'(w));
      check_eq($sformatf("stream_v%0d", w), 32'(v_out),    32'd1);
    end
    v_in = 1'b0;
    step();
    check_eq("stream_empty", 32'(v_out),    32'd0);
    check_eq("stream_hold",  32'(data_out), 32'd7);
    check_eq("stream_ovf",   32'(overflow), 32'd0);

    // Overflow on a stalled full slot.
    ready   = 1'b0;
    v_in    = 1'b1;
    data_in = 16'h0001;
    step();
    check_eq("ovf_first_d", 32'(data_out), 32'h1);
    check_eq("ovf_first_f", 32'(overflow), 32'd0);
    data_in = 16'h0002;
    step();
    check_eq("ovf_drop_d", 32'(data_out), 32'h1);
    check_eq("ovf_drop_f", 32'(overflow), 32'd1);
    v_in = 1'b0;
    step();
    check_eq("ovf_sticky", 32'(overflow), 32'd1);
    check_eq("ovf_keep_v", 32'(v_out),    32'd1);

    // Drain with a stalled consumer, then release.
    iso_req = 1'b1;
    step();
    check_eq("drain_en",  32'(en),      32'd0);
    check_eq("drain_ack", 32'(iso_ack), 32'd0);
    step();
    check_eq("drain_wait_ack", 32'(iso_ack), 32'd0);
    check_eq("drain_wait_v",   32'(v_out),   32'd1);
    ready = 1'b1;
    step();
    check_eq("drain_deq_v",   32'(v_out),   32'd0);
    check_eq("drain_deq_ack", 32'(iso_ack), 32'd0);
    step();
    check_eq("drain_done_ack", 32'(iso_ack), 32'd1);
    ready   = 1'b0;
    iso_req = 1'b0;

    // Power loss during WAKE.
    step();
    check_eq("pl_wake_en", 32'(en), 32'd1);
    pg = 1'b0;
    step_n(sync_lp);
    check_eq("pl_wake_hold", 32'(en), 32'd1);
    step();
    check_eq("pl_wake_off", 32'(en),      32'd0);
    check_eq("pl_wake_ack", 32'(iso_ack), 32'd1);

    // Power loss during ACTIVE with a word buffered.
    pg = 1'b1;
    step_n(sync_lp);
    step();
    step_n(4);
    v_in    = 1'b1;
    data_in = 16'h5A5A;
    step();
    check_eq("pl_act_cap", 32'(data_out), 32'h5A5A);
    v_in = 1'b0;
    pg   = 1'b0;
    step_n(sync_lp);
    step();
    check_eq("pl_act_en",  32'(en),      32'd0);
    check_eq("pl_act_ack", 32'(iso_ack), 32'd1);
    check_eq("pl_act_v",   32'(v_out),   32'd1);
    ready = 1'b1;
    step();
    check_eq("pl_act_deq",  32'(v_out),    32'd0);
    check_eq("pl_act_hold", 32'(data_out), 32'h5A5A);
    ready = 1'b0;

    // Asynchronous reset mid-ACTIVE with a word held and overflow set.
    pg = 1'b1;
    step_n(sync_lp);
    step();
    step_n(4);
    v_in    = 1'b1;
    data_in = 16'h1234;
    step();
    v_in = 1'b0;
    check_eq("ar_pre_v",  32'(v_out), 32'd1);
    check_eq("ar_pre_en", 32'(en),    32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("ar_en",   32'(en),       32'd0);
    check_eq("ar_v",    32'(v_out),    32'd0);
    check_eq("ar_ack",  32'(iso_ack),  32'd1);
    check_eq("ar_ovf",  32'(overflow), 32'd0);
    check_eq("ar_data", 32'(data_out), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/bsg_level_shift_iso_capture.md
Name: bsg_level_shift_iso_capture

Overview:
- Downstream v1-domain stage that consumes the output of the up/down level-shift sink.
- Owns the sink's enable (isolation) control with a power-up settle sequence.
- Registers the shifted data and valid into a single-entry output buffer with a valid/ready handshake.
- Sequences a clean isolate/drain on request or on loss of v0 power.

Parameters:
- width_p, 16, data width; matches the sink's data width.
- settle_cycles_p, 4, cycles en_o stays high before captures are allowed; legal range 1..255.

Ports:
- clk_i  in  1  v1-domain clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- v0_pwr_good_i  in  1  v0 power-good indication.
- iso_req_i  in  1  request to isolate v0 (level-sensitive).
- en_o  out  1  drives the sink's v1_en_i.
- v_i  in  1  valid from the v0 domain, passed through the sink and gated by en_o.
- data_i  in  width_p  v1_data_o from the sink.
- v_o  out  1  output buffer holds valid data.
- data_o  out  width_p  buffered data.
- ready_i  in  1  consumer accepts data_o when v_o & ready_i.
- iso_ack_o  out  1  high while isolated (state ISO).
- overflow_o  out  1  sticky flag; a capture was dropped.

Behaviour:
- Reset is asynchronous and active-low, clocked by clk_i. On reset:
  - state=ISO, en_o=0, v_o=0, data_o=0, iso_ack_o=1, overflow_o=0, settle counter=0.
- pg_s is the power-good seen by the FSM: v0_pwr_good_i, or its synchronised version (see Optional Feature).
- en_o = (state==WAKE | state==ACTIVE), decoded directly from the state register; there is no extra flop on en_o.
- FSM:
  - ISO: if pg_s & ~iso_req_i, go to WAKE and load cnt = settle_cycles_p-1.
  - WAKE:
    - if ~pg_s, go to ISO.
    - else if cnt==0, go to ACTIVE.
    - else decrement cnt.
    - No captures in WAKE. Exactly settle_cycles_p cycles are spent in WAKE.
  - ACTIVE:
    - if ~pg_s, go to ISO immediately; the buffered entry is retained and stays presentable.
    - else if iso_req_i, go to DRAIN.
  - DRAIN:
    - en_o=0, no captures.
    - Go to ISO in the cycle after v_o==0 is observed.
    - If ~pg_s, go to ISO immediately.
  - If ~pg_s and iso_req_i are both true, the ~pg_s transition wins.
- Capture:
  - Enabled only in ACTIVE. A capture occurs when v_i=1.
  - Accept condition: ~v_o | ready_i. Enqueue and dequeue in the same cycle is allowed, giving full throughput.
  - If v_i=1 while v_o=1 & ~ready_i: the data is dropped, the buffer is unchanged, and overflow_o is set.
  - overflow_o is cleared only by reset.
- Dequeue:
  - v_o & ready_i clears v_o unless a capture occurs in the same cycle.
  - Allowed in every state, including ISO.
- Latency: data_i/v_i sampled at edge N appear on data_o/v_o after edge N (1 cycle).
- data_o holds its value when not capturing; it is not cleared on dequeue.

Optional Feature:
- Macro: BSG_LEVEL_SHIFT_ISO_SYNC_EN.
- Defined: v0_pwr_good_i passes through a 2-flop synchroniser, reset to 0, before use as pg_s. This adds 2 cycles to wake entry and to the power-loss reaction.
- Undefined: pg_s = v0_pwr_good_i directly; the integrator guarantees it is synchronous to clk_i.

Decomposition:
- Shared package bsg_level_shift_pkg holds:
  - enum bsg_ls_iso_state_e {ISO, WAKE, ACTIVE, DRAIN} (2 bits).
  - localparam bsg_ls_settle_max_lp = 255.
- Settle counter width: $clog2(settle_cycles_p+1).
- One natural sub-module: bsg_level_shift_iso_fsm (state register, settle counter, en_o/iso_ack_o decode).
- The capture buffer stays inline in the top module.

Test Plan:
- Reset check: assert reset_n_i low mid-ACTIVE with v_o=1.
  - Expect en_o=0, v_o=0, iso_ack_o=1, overflow_o=0 asynchronously, before the next edge.
- Wake timing (no macro, settle_cycles_p=4): raise pg at edge 0.
  - en_o=1 from edge 1; a v_i at edges 1–4 is ignored.
  - A v_i at edge 5 yields v_o=1 after edge 5 (with data_i=16'hA5A5 sampled, data_o=16'hA5A5).
- Back-to-back streaming: with ready_i=1 in ACTIVE, send 8 consecutive words 0..7.
  - data_o shows 0..7 on consecutive cycles; overflow_o stays 0.
- Overflow: with ready_i=0, send 16'h0001 then 16'h0002.
  - data_o stays 16'h0001; overflow_o=1 and sticky.
- Drain: with v_o=1 and ready_i=0, raise iso_req_i.
  - en_o=0 next cycle and the state stays DRAIN.
  - Raise ready_i: iso_ack_o=1 two cycles later.
- Power loss: drop pg in WAKE and separately in ACTIVE.
  - Each case: ISO next cycle, en_o=0, buffered word still dequeuable.
  - With the macro defined: reaction occurs 2 cycles later.
